// File: rtl/sv_mm_seq.sv
// Interleaved modular multiplier sequencer: res = x*y mod q, one double-and-add step per clock, MSB of y first.
// Optional macro SV_MM_SEQ_UNROLL2_EN chains two steps per clock (DATA_WIDTH must be even).

module sv_mf #(
  parameter int unsigned DATA_WIDTH = 128
) (
  input  logic [DATA_WIDTH-1:0] q_i,
  input  logic [DATA_WIDTH-1:0] x_i,
  input  logic [DATA_WIDTH-1:0] y_i,
  input  logic [DATA_WIDTH-1:0] z_i,
  output logic [DATA_WIDTH-1:0] y_o,
  output logic [DATA_WIDTH-1:0] z_o
);
  localparam int unsigned W = DATA_WIDTH;

  logic [W:0]   dbl;
  logic [W-1:0] dbl_red;
  logic [W:0]   sum;

  // z' = 2z mod q, then + x mod q when the current y MSB is set; z < q keeps both sums below 2q
  always_comb begin
    dbl     = {z_i, 1'b0};
    dbl_red = (dbl >= {1'b0, q_i}) ? W'(dbl - {1'b0, q_i}) : dbl[W-1:0];
    sum     = {1'b0, dbl_red} + {1'b0, x_i};
    if (y_i[W-1]) begin
      z_o = (sum >= {1'b0, q_i}) ? W'(sum - {1'b0, q_i}) : sum[W-1:0];
    end else begin
      z_o = dbl_red;
    end
    y_o = {y_i[W-2:0], 1'b0};
  end
endmodule

module sv_mm_seq #(
  parameter int unsigned DATA_WIDTH = 128
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [DATA_WIDTH-1:0] q_i,
  input  logic [DATA_WIDTH-1:0] x_i,
  input  logic [DATA_WIDTH-1:0] y_i,
  input  logic                  abort_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [DATA_WIDTH-1:0] res_o,
  output logic                  busy_o
);
  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
`ifdef SV_MM_SEQ_UNROLL2_EN
  localparam int unsigned STEPS = DATA_WIDTH / 2;
`else
  localparam int unsigned STEPS = DATA_WIDTH;
`endif
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  q_reg, x_reg, y_reg, z_reg;
  logic [W-1:0]  y_nxt, z_nxt;
  logic [CW-1:0] cnt;

`ifdef SV_MM_SEQ_UNROLL2_EN
  if (DATA_WIDTH % 2 != 0) begin : g_odd_width
    $error("sv_mm_seq: DATA_WIDTH must be even when two steps are chained per cycle");
  end

  logic [W-1:0] y_mid, z_mid;

  sv_mf #(.DATA_WIDTH(W)) u_mf0 (
    .q_i(q_reg), .x_i(x_reg), .y_i(y_reg), .z_i(z_reg), .y_o(y_mid), .z_o(z_mid)
  );
  sv_mf #(.DATA_WIDTH(W)) u_mf1 (
    .q_i(q_reg), .x_i(x_reg), .y_i(y_mid), .z_i(z_mid), .y_o(y_nxt), .z_o(z_nxt)
  );
`else
  sv_mf #(.DATA_WIDTH(W)) u_mf0 (
    .q_i(q_reg), .x_i(x_reg), .y_i(y_reg), .z_i(z_reg), .y_o(y_nxt), .z_o(z_nxt)
  );
`endif

  // Control FSM; every output is a register updated alongside the state
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state       <= IDLE;
      req_ready_o <= 1'b1;
      res_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      res_o       <= '0;
      q_reg       <= '0;
      x_reg       <= '0;
      y_reg       <= '0;
      z_reg       <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            q_reg       <= q_i;
            x_reg       <= x_i;
            y_reg       <= y_i;
            z_reg       <= '0;
            cnt         <= '0;
            state       <= RUN;
            req_ready_o <= 1'b0;
            busy_o      <= 1'b1;
          end
        end
        RUN: begin
          // Abort wins over completion; operand registers keep their partial contents
          if (abort_i) begin
            state       <= IDLE;
            req_ready_o <= 1'b1;
            busy_o      <= 1'b0;
          end else begin
            y_reg <= y_nxt;
            z_reg <= z_nxt;
            cnt   <= cnt + CW'(1);
            if (cnt == LAST) begin
              state       <= DONE;
              res_o       <= z_nxt;
              res_valid_o <= 1'b1;
              busy_o      <= 1'b0;
            end
          end
        end
        DONE: begin
          if (res_ready_i) begin
            state       <= IDLE;
            res_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          req_ready_o <= 1'b1;
          res_valid_o <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sv_mm_seq.sv
// Bench for sv_mm_seq: directed and random requests on an 8-bit and a 128-bit instance, scoreboarded against x*y%q.

module tb_sv_mm_seq;
  localparam int unsigned W  = 8;
  localparam int unsigned WW = 128;
`ifdef SV_MM_SEQ_UNROLL2_EN
  localparam int LAT8 = W / 2 + 1;
  localparam int LATW = WW / 2 + 1;
`else
  localparam int LAT8 = W + 1;
  localparam int LATW = WW + 1;
`endif

  logic clk = 1'b0;
  logic rst_n;

  logic         req_valid, req_ready, abort, res_valid, res_ready, busy;
  logic [W-1:0] q, x, y, res;

  logic          req_valid_w, req_ready_w, res_valid_w, res_ready_w, busy_w;
  logic [WW-1:0] q_w, x_w, y_w, res_w;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  logic [W-1:0]  sb8[$];
  logic [WW-1:0] sbw[$];

  always #5 clk = ~clk;

  sv_mm_seq #(.DATA_WIDTH(W)) dut8 (
    .clk_i(clk), .arstn_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .q_i(q), .x_i(x), .y_i(y), .abort_i(abort),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_o(res), .busy_o(busy)
  );

  sv_mm_seq #(.DATA_WIDTH(WW)) dutw (
    .clk_i(clk), .arstn_i(rst_n),
    .req_valid_i(req_valid_w), .req_ready_o(req_ready_w),
    .q_i(q_w), .x_i(x_w), .y_i(y_w), .abort_i(1'b0),
    .res_valid_o(res_valid_w), .res_ready_i(res_ready_w), .res_o(res_w), .busy_o(busy_w)
  );

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One 8-bit transaction; called at a negedge, returns at a negedge with the block idle
  task automatic run8(input logic [W-1:0] qv, input logic [W-1:0] xv, input logic [W-1:0] yv,
                      input int hold);
    int edges;
    int guard;
    logic [W-1:0] e;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_before_req", req_ready, 1);
    req_valid = 1'b1;
    q = qv; x = xv; y = yv;
    sb8.push_back(W'((16'(xv) * 16'(yv)) % 16'(qv)));
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("busy_in_run", busy, 1);
    chk("ready_low_in_run", req_ready, 0);
    while (!res_valid && edges < 300) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk("latency_edges", edges, LAT8);
    e = sb8.pop_front();
    chk("res", res, e);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      q = 8'd13; x = 8'd1; y = 8'd1;
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", res_valid, 1);
      chk("hold_res", res, e);
      chk("hold_ready_low", req_ready, 0);
    end
    req_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    chk("valid_drop", res_valid, 0);
    chk("ready_back", req_ready, 1);
    chk("busy_idle", busy, 0);
  endtask

  task automatic runw(input logic [WW-1:0] qv, input logic [WW-1:0] xv, input logic [WW-1:0] yv);
    int edges;
    logic [2*WW-1:0] a, b, m;
    logic [WW-1:0] e;
    a = {{WW{1'b0}}, xv};
    b = {{WW{1'b0}}, yv};
    m = {{WW{1'b0}}, qv};
    sbw.push_back(WW'((a * b) % m));
    req_valid_w = 1'b1;
    q_w = qv; x_w = xv; y_w = yv;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    req_valid_w = 1'b0;
    chk("w_busy", busy_w, 1);
    while (!res_valid_w && edges < 1000) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk("w_latency_edges", edges, LATW);
    e = sbw.pop_front();
    chk("w_res", res_w, e);
    res_ready_w = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready_w = 1'b0;
    chk("w_ready_back", req_ready_w, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw;
    logic [W-1:0] rq, rx, ry;
    logic [WW-1:0] wq, wx, wy;

    rst_n = 1'b0;
    req_valid = 1'b0; abort = 1'b0; res_ready = 1'b0;
    q = '0; x = '0; y = '0;
    req_valid_w = 1'b0; res_ready_w = 1'b0;
    q_w = '0; x_w = '0; y_w = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res", res, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run8(8'd251, 8'd200, 8'd3, 0);
    run8(8'd251, 8'd250, 8'd255, 0);
    run8(8'd251, 8'd0, 8'd255, 0);
    run8(8'd251, 8'd17, 8'd0, 0);
    run8(8'd251, 8'd123, 8'd45, 5);
    chk("hold_no_new_req_busy", busy, 0);

    // Abort during the fourth step
    req_valid = 1'b1;
    q = 8'd251; x = 8'd200; y = 8'd3;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_ready", req_ready, 1);
    chk("abort_busy", busy, 0);
    saw = 1'b0;
    repeat (W + 4) begin
      @(negedge clk);
      if (res_valid) saw = 1'b1;
    end
    chk("abort_no_result", saw, 0);
    run8(8'd13, 8'd5, 8'd7, 0);

    // Asynchronous reset between edges while running
    req_valid = 1'b1;
    q = 8'd251; x = 8'd250; y = 8'd255;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", req_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", res_valid, 0);
    chk("midrst_res", res, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      rq = W'($urandom_range(2, 255));
      rx = W'($urandom % 32'(rq));
      ry = W'($urandom);
      run8(rq, rx, ry, 0);
    end

    for (int i = 0; i < 4; i++) begin
      wq = {$urandom, $urandom, $urandom, $urandom};
      wq[WW-1] = 1'b1;
      wq[0] = i[0];
      wx = {$urandom, $urandom, $urandom, $urandom};
      wx = wx % wq;
      wy = {$urandom, $urandom, $urandom, $urandom};
      runw(wq, wx, wy);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
